// File: rtl/nibble_parity_pkg.sv
// nibble_parity_pkg
// Shared definitions for the nibble parity checker:
//   - state_e     : FSM state encoding (IDLE / ACCUM / REPORT)
//   - NIBBLE_W    : width of one data beat
//   - exp_parity(): expected parity bit of a nibble for a given parity sense
package nibble_parity_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_e;

    // Even parity: the parity bit equals the XOR of the data bits.
    // Odd parity inverts it.
    function automatic logic exp_parity(input logic [NIBBLE_W-1:0] data,
                                        input logic                odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/nibble_parity_if.sv
// nibble_parity_if
// Bundles the beat handshake and the per-frame result bus of the checker.
// Handshake: a beat transfers on a rising clk edge where in_valid and
// in_ready are both 1; in_data/in_parity are only meaningful at that edge,
// and in_ready never depends on in_valid.
//   master : upstream / result consumer (drives in_valid, in_data, in_parity)
//   slave  : the checker (drives in_ready, frame_* results, counters, state_dbg)
// state_dbg exposes the checker's FSM state for observation.
interface nibble_parity_if
    import nibble_parity_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [NIBBLE_W-1:0]  in_data;
    logic                 in_parity;
    logic                 frame_done;
    logic                 frame_err;
    logic [NIBBLE_W-1:0]  frame_xor;
    logic [CNT_W-1:0]     frame_count;
    logic [CNT_W-1:0]     err_count;
    state_e               state_dbg;

    modport master (
        output in_valid, in_data, in_parity,
        input  in_ready, frame_done, frame_err, frame_xor,
               frame_count, err_count, state_dbg
    );

    modport slave (
        input  in_valid, in_data, in_parity,
        output in_ready, frame_done, frame_err, frame_xor,
               frame_count, err_count, state_dbg
    );
endinterface

// File: rtl/nibble_parity_bit.sv
// nibble_parity_bit
// Combinational per-beat parity check.
//   data     in  4  nibble {a,b,c,d}
//   parity   in  1  parity bit delivered with the nibble
//   beat_err out 1  1 when parity differs from the expected bit
module nibble_parity_bit
    import nibble_parity_pkg::*;
#(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic [NIBBLE_W-1:0] data,
    input  logic                parity,
    output logic                beat_err
);
    assign beat_err = exp_parity(data, PARITY_ODD) != parity;
endmodule

// File: rtl/nibble_parity_checker.sv
// nibble_parity_checker
// Groups parity-tagged nibbles into frames of FRAME_LEN beats, checks the
// parity of every beat and reports one result per frame.
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  slave side of nibble_parity_if:
//        in_valid/in_ready/in_data/in_parity  beat handshake
//        frame_done  one-cycle pulse while the frame result is presented
//        frame_err   any beat of the frame failed parity (with frame_done)
//        frame_xor   XOR of all nibbles of the frame (with frame_done)
//        frame_count completed frames, wraps
//        err_count   erroneous frames, saturates
//        state_dbg   current FSM state
module nibble_parity_checker
    import nibble_parity_pkg::*;
#(
    parameter int FRAME_LEN  = 4,
    parameter int CNT_W      = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    nibble_parity_if.slave  bus
);
    localparam int                BCW       = $clog2(FRAME_LEN + 1);
    localparam logic [BCW-1:0]    BEAT_ONE  = BCW'(1);
    localparam logic [BCW-1:0]    LAST_BEAT = BCW'(FRAME_LEN);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_e               state_q, state_d;
    logic [BCW-1:0]       beat_cnt_q, beat_cnt_d;
    logic [NIBBLE_W-1:0]  acc_xor_q, acc_xor_d;
    logic                 err_flag_q, err_flag_d;
    logic [CNT_W-1:0]     frame_count_q, frame_count_d;
    logic [CNT_W-1:0]     err_count_q, err_count_d;

    logic beat_err;
    logic xfer;
    logic in_report;

    nibble_parity_bit #(
        .PARITY_ODD (PARITY_ODD)
    ) u_bit (
        .data     (bus.in_data),
        .parity   (bus.in_parity),
        .beat_err (beat_err)
    );

    // REPORT is the single bubble in which beats are refused.
    assign in_report    = (state_q == REPORT);
    assign bus.in_ready = ~in_report;
    assign xfer         = bus.in_valid & ~in_report;

    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        acc_xor_d     = acc_xor_q;
        err_flag_d    = err_flag_q;
        frame_count_d = frame_count_q;
        err_count_d   = err_count_q;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    // First beat reloads the accumulators instead of merging.
                    beat_cnt_d = BEAT_ONE;
                    acc_xor_d  = bus.in_data;
                    err_flag_d = beat_err;
                    state_d    = (FRAME_LEN == 1) ? REPORT : ACCUM;
                end
            end
            ACCUM: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + BEAT_ONE;
                    acc_xor_d  = acc_xor_q ^ bus.in_data;
                    err_flag_d = err_flag_q | beat_err;
                    if (beat_cnt_d == LAST_BEAT) begin
                        state_d = REPORT;
                    end
                end
            end
            REPORT: begin
                frame_count_d = frame_count_q + CNT_ONE;
                if (err_flag_q && (err_count_q != '1)) begin
                    err_count_d = err_count_q + CNT_ONE;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            beat_cnt_q    <= '0;
            acc_xor_q     <= '0;
            err_flag_q    <= 1'b0;
            frame_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            acc_xor_q     <= acc_xor_d;
            err_flag_q    <= err_flag_d;
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
        end
    end

    // Results are gated by REPORT so they read 0 outside the result cycle.
    assign bus.frame_done  = in_report;
    assign bus.frame_err   = in_report & err_flag_q;
    assign bus.frame_xor   = in_report ? acc_xor_q : '0;
    assign bus.frame_count = frame_count_q;
    assign bus.err_count   = err_count_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_nibble_parity_checker.sv
module tb_nibble_parity_checker;
    import nibble_parity_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    // sel 0: FRAME_LEN=4 CNT_W=8 even ; sel 1: FRAME_LEN=4 CNT_W=2 even ;
    // sel 2: FRAME_LEN=1 CNT_W=8 odd
    nibble_parity_if #(.CNT_W(8)) if_a ();
    nibble_parity_if #(.CNT_W(2)) if_b ();
    nibble_parity_if #(.CNT_W(8)) if_c ();

    nibble_parity_checker #(.FRAME_LEN(4), .CNT_W(8), .PARITY_ODD(1'b0))
        u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    nibble_parity_checker #(.FRAME_LEN(4), .CNT_W(2), .PARITY_ODD(1'b0))
        u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    nibble_parity_checker #(.FRAME_LEN(1), .CNT_W(8), .PARITY_ODD(1'b1))
        u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    int         sel;
    logic       drv_valid;
    logic [3:0] drv_data;
    logic       drv_parity;

    assign if_a.in_valid  = drv_valid && (sel == 0);
    assign if_b.in_valid  = drv_valid && (sel == 1);
    assign if_c.in_valid  = drv_valid && (sel == 2);
    assign if_a.in_data   = drv_data;
    assign if_b.in_data   = drv_data;
    assign if_c.in_data   = drv_data;
    assign if_a.in_parity = drv_parity;
    assign if_b.in_parity = drv_parity;
    assign if_c.in_parity = drv_parity;

    logic       obs_ready, obs_done, obs_err;
    logic [3:0] obs_xor;
    logic [7:0] obs_fc, obs_ec;
    logic [1:0] obs_state;

    always_comb begin
        obs_ready = if_a.in_ready;
        obs_done  = if_a.frame_done;
        obs_err   = if_a.frame_err;
        obs_xor   = if_a.frame_xor;
        obs_fc    = if_a.frame_count;
        obs_ec    = if_a.err_count;
        obs_state = if_a.state_dbg;
        case (sel)
            1: begin
                obs_ready = if_b.in_ready;
                obs_done  = if_b.frame_done;
                obs_err   = if_b.frame_err;
                obs_xor   = if_b.frame_xor;
                obs_fc    = {6'd0, if_b.frame_count};
                obs_ec    = {6'd0, if_b.err_count};
                obs_state = if_b.state_dbg;
            end
            2: begin
                obs_ready = if_c.in_ready;
                obs_done  = if_c.frame_done;
                obs_err   = if_c.frame_err;
                obs_xor   = if_c.frame_xor;
                obs_fc    = if_c.frame_count;
                obs_ec    = if_c.err_count;
                obs_state = if_c.state_dbg;
            end
            default: ;
        endcase
    end

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int m_frames[3];
    int m_errs[3];

    logic [3:0] q_data[$];
    bit         q_par[$];
    int         q_gap[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cnt_width(input int s);
        return (s == 1) ? 2 : 8;
    endfunction

    // Parity rule from the number of ones: even sense wants an even total
    // count of ones over data+parity, odd sense wants an odd total.
    function automatic bit good_parity(input logic [3:0] d, input int s);
        int odd;
        odd = (s == 2) ? 1 : 0;
        return bit'(($countones(d) + odd) % 2);
    endfunction

    function automatic int exp_fc(input int s);
        return m_frames[s] % (1 << cnt_width(s));
    endfunction

    function automatic int exp_ec(input int s);
        int lim;
        lim = (1 << cnt_width(s)) - 1;
        return (m_errs[s] > lim) ? lim : m_errs[s];
    endfunction

    // ---------------- driver tasks ----------------
    // All tasks start and end just after a falling edge.
    task automatic send_beat(input logic [3:0] d, input bit p);
        int guard;
        guard      = 0;
        drv_valid  = 1'b1;
        drv_data   = d;
        drv_parity = p;
        while (obs_ready !== 1'b1 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 8) check("ready_timeout", {31'd0, obs_ready}, 32'd1);
        @(negedge clk);
        drv_valid = 1'b0;
    endtask

    // Sends the frame held in q_data/q_par/q_gap, checks the result cycle and
    // the counters afterwards. With junk=1 a random beat is offered during the
    // result cycle; it must not be consumed.
    task automatic run_frame(input string tag, input bit junk);
        logic [3:0] x;
        bit         e;
        x = 4'h0;
        e = 1'b0;
        foreach (q_data[i]) begin
            x ^= q_data[i];
            if (q_par[i] != good_parity(q_data[i], sel)) e = 1'b1;
        end
        foreach (q_data[i]) begin
            repeat (q_gap[i]) begin
                drv_valid = 1'b0;
                @(negedge clk);
            end
            if (i > 0) check({tag, "_early_done"}, {31'd0, obs_done}, 32'd0);
            send_beat(q_data[i], q_par[i]);
        end
        check({tag, "_done"},  {31'd0, obs_done},  32'd1);
        check({tag, "_ready"}, {31'd0, obs_ready}, 32'd0);
        check({tag, "_state"}, {30'd0, obs_state}, 32'd2);
        check({tag, "_err"},   {31'd0, obs_err},   {31'd0, e});
        check({tag, "_xor"},   {28'd0, obs_xor},   {28'd0, x});
        m_frames[sel]++;
        if (e) m_errs[sel]++;
        if (junk) begin
            drv_valid  = 1'b1;
            drv_data   = 4'($urandom_range(0, 15));
            drv_parity = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        drv_valid = 1'b0;
        check({tag, "_done_clr"}, {31'd0, obs_done}, 32'd0);
        check({tag, "_fcount"},   {24'd0, obs_fc},   32'(exp_fc(sel)));
        check({tag, "_ecount"},   {24'd0, obs_ec},   32'(exp_ec(sel)));
    endtask

    task automatic load_rand_frame(input int len);
        q_data.delete();
        q_par.delete();
        q_gap.delete();
        for (int i = 0; i < len; i++) begin
            logic [3:0] d;
            d = 4'($urandom_range(0, 15));
            q_data.push_back(d);
            q_par.push_back(good_parity(d, sel) ^ ($urandom_range(0, 4) == 0));
            q_gap.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, obs_ready}, 32'd1);
        check({tag, "_done"},  {31'd0, obs_done},  32'd0);
        check({tag, "_err"},   {31'd0, obs_err},   32'd0);
        check({tag, "_xor"},   {28'd0, obs_xor},   32'd0);
        check({tag, "_fc"},    {24'd0, obs_fc},    32'd0);
        check({tag, "_ec"},    {24'd0, obs_ec},    32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        sel        = 0;
        drv_valid  = 1'b0;
        drv_data   = 4'h0;
        drv_parity = 1'b0;
        rst        = 1'b1;
        for (int s = 0; s < 3; s++) begin
            m_frames[s] = 0;
            m_errs[s]   = 0;
        end

        // reset values
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", {31'd0, obs_ready}, 32'd1);

        // good frame, continuous valid
        q_data = {4'h1, 4'h3, 4'h7, 4'hF};
        q_par  = {1'b1, 1'b0, 1'b1, 1'b0};
        q_gap  = {0, 0, 0, 0};
        run_frame("good", 1'b0);
        check("good_fc_lit", {24'd0, obs_fc}, 32'd1);

        // second beat with wrong parity, junk offered during result cycle
        q_par = {1'b1, 1'b1, 1'b1, 1'b0};
        run_frame("bad2", 1'b1);
        check("bad2_ec_lit", {24'd0, obs_ec}, 32'd1);

        // same good frame with an idle gap between beats 2 and 3
        q_par = {1'b1, 1'b0, 1'b1, 1'b0};
        q_gap = {0, 0, 3, 0};
        run_frame("gap", 1'b0);

        // random frames with random gaps and parity faults
        for (int f = 0; f < 8; f++) begin
            load_rand_frame(4);
            run_frame("rand_a", 1'($urandom_range(0, 1)));
        end

        // reset in the middle of a frame
        send_beat(4'h5, 1'b0);
        send_beat(4'h6, 1'b0);
        rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            m_frames[s] = 0;
            m_errs[s]   = 0;
        end
        @(negedge clk);
        check_reset_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, obs_done}, 32'd0);
        end
        q_data = {4'h1, 4'h3, 4'h7, 4'hF};
        q_par  = {1'b1, 1'b0, 1'b1, 1'b0};
        q_gap  = {0, 0, 0, 0};
        run_frame("post_rst", 1'b0);
        check("post_rst_fc_lit", {24'd0, obs_fc}, 32'd1);

        // narrow counters: 5 bad frames
        sel    = 1;
        q_data = {4'h1, 4'h3, 4'h7, 4'hF};
        q_par  = {1'b0, 1'b0, 1'b1, 1'b0};
        for (int f = 0; f < 5; f++) begin
            run_frame("sat", 1'b0);
        end
        check("sat_fc_lit", {24'd0, obs_fc}, 32'd1);
        check("sat_ec_lit", {24'd0, obs_ec}, 32'd3);
        for (int f = 0; f < 3; f++) begin
            load_rand_frame(4);
            run_frame("rand_b", 1'b1);
        end

        // single-beat frames, odd parity
        sel    = 2;
        q_data = {4'h0};
        q_par  = {1'b1};
        q_gap  = {0};
        run_frame("len1_ok", 1'b1);
        q_par = {1'b0};
        run_frame("len1_bad", 1'b0);
        for (int f = 0; f < 6; f++) begin
            load_rand_frame(1);
            run_frame("rand_c", 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
